fifo_tx_serializer: RTL and testbench
=====================================

FIFO_TX_SERIALIZER -- requirements
Module: fifo_tx_serializer

Interface
REQ-001 SHALL have parameter FBITS, default 8: data word width in bits, minimum 1.
REQ-002 SHALL have parameter DIVISOR, default 16: clock cycles per serial bit, minimum 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rstn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port clr, input, 1: synchronous clear, active-high.
REQ-006 SHALL have port src_valid, input, 1: the upstream one-word buffer holds a word.
REQ-007 SHALL have port src_data, input, FBITS: the word held by the upstream buffer.
REQ-008 SHALL have port src_rd, output, 1: one-cycle pulse meaning the word has been consumed; it drives the upstream rd_fifo.
REQ-009 SHALL have port txd, output, 1: serial output line, idle high.
REQ-010 SHALL have port busy, output, 1: high whenever a frame is in progress.

Function
REQ-011 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP; PARITY exists only per REQ-025.
REQ-012 In IDLE with src_valid=1 and clr=0, SHALL latch src_data into a shift register, pulse src_rd for exactly that cycle, and enter START on the next edge.
REQ-013 Accept-to-output latency SHALL be 1 cycle: txd goes low in the cycle after the src_rd pulse.
REQ-014 Each of START, each DATA bit, PARITY and STOP SHALL last exactly DIVISOR cycles, timed by a bit counter that runs 0..DIVISOR-1 and wraps.
REQ-015 txd SHALL be 0 in START, 1 in STOP and 1 in IDLE.
REQ-016 DATA SHALL send FBITS bits, LSB first, with a bit index counter 0..FBITS-1; after the last bit it goes to PARITY if enabled, otherwise to STOP.
REQ-017 In the final cycle of STOP, SHALL behave as follows:
- src_valid=1: latch the word, pulse src_rd and go straight to START, with no idle cycle between frames.
- src_valid=0: go to IDLE.
REQ-018 src_rd SHALL never be asserted outside the cycles named in REQ-012 and REQ-017, and never on two consecutive cycles.
REQ-019 busy SHALL be 0 only in IDLE; the src_rd cycle in IDLE still shows busy=0.
REQ-020 clr=1 SHALL override everything on the next edge:
- state becomes IDLE, txd=1, src_rd=0, counters 0;
- src_valid is ignored while clr=1.
REQ-021 Changes on src_data during a frame SHALL have no effect on the frame in progress.

Reset
REQ-022 While rstn=0, SHALL asynchronously force state=IDLE, txd=1, src_rd=0, busy=0, shift register=0 and both counters=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately, with no src_rd pulse; after release, SHALL resume from IDLE on the first rising clk edge.

Configuration
REQ-024 SHALL be controlled by the macro FIFO_TX_SERIALIZER_PARITY_EN.
REQ-025 With FIFO_TX_SERIALIZER_PARITY_EN defined:
- a PARITY bit period is inserted between DATA and STOP;
- txd carries even parity, i.e. the XOR of the FBITS latched bits;
- frame length is (FBITS+3)*DIVISOR cycles.
REQ-026 Without the macro, the PARITY state and its logic SHALL be absent, and frame length is (FBITS+2)*DIVISOR cycles.

Structure
REQ-027 Package fifo_tx_serializer_pkg SHALL hold:
- the FSM state enum;
- the constant TXD_IDLE=1;
- the constant DIVISOR_MIN=2.
REQ-028 Sub-module fifo_tx_serializer_baud SHALL hold the bit-period counter and output a one-cycle bit_end pulse; it is restarted on accept and on clr.

Verification (FBITS=8, DIVISOR=4, parity disabled unless stated)
REQ-029 src_valid=1 with src_data=0xA5 at cycle 0 SHALL produce:
- src_rd=1 at cycle 0;
- over cycles 1..40, txd = 0,1,0,1,0,0,1,0,1,1, each held for 4 cycles;
- busy=0 at cycle 41.
REQ-030 Words 0x00 then 0xFF, back-to-back with src_valid held high, SHALL produce:
- src_rd pulses at cycles 0 and 40;
- the second start bit at cycle 41;
- no idle-high gap between the frames.
REQ-031 clr=1 at cycle 15 of the 0xA5 frame SHALL give txd=1, busy=0 and state=IDLE at cycle 16, with no src_rd pulse while clr is high.
REQ-032 rstn=0 at cycle 10 of a frame SHALL give txd=1 and busy=0 immediately, with no clock edge needed; after release with src_valid=1, src_rd SHALL pulse on the first edge.
REQ-033 With FIFO_TX_SERIALIZER_PARITY_EN defined, SHALL produce:
- for 0x01: parity bit 1 at cycles 37..40, stop bit at cycles 41..44;
- for 0xA5: parity bit 0;
- src_rd for a waiting second word at cycle 44.

Source files
------------

// File: rtl/fifo_tx_serializer_pkg.sv
// Shared definitions for the FIFO-fed serial transmitter.
// Optional feature macro: FIFO_TX_SERIALIZER_PARITY_EN adds an even-parity bit.
package fifo_tx_serializer_pkg;

    // The serial line rests high between frames
    localparam logic TXD_IDLE = 1'b1;

    // Smallest bit period the baud counter is designed for
    localparam int DIVISOR_MIN = 2;

    // Frame sequencing states; PARITY only exists in the parity build
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/fifo_tx_serializer_baud.sv
// Bit-period timer: counts 0..DIVISOR-1 while a frame runs and flags the
// last cycle of every bit period with a one-cycle bit_end pulse.
module fifo_tx_serializer_baud
    import fifo_tx_serializer_pkg::*;
#(
    parameter int DIVISOR = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic restart,
    input  logic run,
    output logic bit_end
);

    localparam int DIV_EFF = (DIVISOR < DIVISOR_MIN) ? DIVISOR_MIN : DIVISOR;
    localparam int CNT_W   = $clog2(DIV_EFF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_EFF - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running period counter, held at zero when idle and realigned on a new word
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr || restart || !run) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_end = run && (cnt == CNT_LAST);

endmodule

// File: rtl/fifo_tx_serializer.sv
// Serializer that pulls words from a one-word upstream buffer and sends them
// as start / data (LSB first) / [parity] / stop frames on txd.
// Optional feature macro: FIFO_TX_SERIALIZER_PARITY_EN inserts an even-parity bit.
module fifo_tx_serializer
    import fifo_tx_serializer_pkg::*;
#(
    parameter int FBITS   = 8,
    parameter int DIVISOR = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             src_valid,
    input  logic [FBITS-1:0] src_data,
    output logic             src_rd,
    output logic             txd,
    output logic             busy
);

    localparam int IDX_W = (FBITS > 1) ? $clog2(FBITS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FBITS - 1);

    tx_state_t        state;
    tx_state_t        state_n;
    logic [FBITS-1:0] shreg;
    logic [FBITS-1:0] shreg_n;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_n;
    logic             accept;
    logic             bit_end;
    logic             run;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
    logic             par;
    logic             par_n;
`endif

    assign run = (state != IDLE);

    fifo_tx_serializer_baud #(
        .DIVISOR (DIVISOR)
    ) u_baud (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (clr),
        .restart (accept),
        .run     (run),
        .bit_end (bit_end)
    );

    // State and datapath registers; reset aborts any frame in progress
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            shreg <= '0;
            idx   <= '0;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            shreg <= shreg_n;
            idx   <= idx_n;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
            par   <= par_n;
`endif
        end
    end

    // Next-state sequencing, word capture and line level for the current state
    always_comb begin
        state_n = state;
        shreg_n = shreg;
        idx_n   = idx;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
        par_n   = par;
`endif
        accept  = 1'b0;
        txd     = TXD_IDLE;

        unique case (state)
            IDLE: begin
                txd = TXD_IDLE;
            end
            START: begin
                txd = 1'b0;
            end
            DATA: begin
                txd = shreg[0];
            end
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
            PARITY: begin
                txd = par;
            end
`endif
            STOP: begin
                txd = 1'b1;
            end
            default: begin
                txd = TXD_IDLE;
            end
        endcase

        if (clr) begin
            state_n = IDLE;
            idx_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (src_valid) begin
                        accept = 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_n = DATA;
                        idx_n   = '0;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shreg_n = shreg >> 1;
                        if (idx == IDX_LAST) begin
                            idx_n = '0;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end
                end
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state_n = STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        if (src_valid) begin
                            accept = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase

            if (accept) begin
                state_n = START;
                shreg_n = src_data;
                idx_n   = '0;
`ifdef FIFO_TX_SERIALIZER_PARITY_EN
                par_n   = ^src_data;
`endif
            end
        end
    end

    // The consume pulse is suppressed while reset is held so upstream never loses a word
    assign src_rd = accept & rstn;
    assign busy   = run;

endmodule

// File: tb/tb_fifo_tx_serializer.sv
// Directed self-checking bench for fifo_tx_serializer (FBITS=8, DIVISOR=4).
// Honours FIFO_TX_SERIALIZER_PARITY_EN to expect the parity bit period.
module tb_fifo_tx_serializer;

`ifdef FIFO_TX_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int DIV  = 4;
    localparam int FLEN = (8 + 2 + PAR) * DIV;

    logic       clk;
    logic       rstn;
    logic       clr;
    logic       src_valid;
    logic [7:0] src_data;
    logic       src_rd;
    logic       txd;
    logic       busy;

    int compared;
    int mismatched;

    fifo_tx_serializer #(
        .FBITS   (8),
        .DIVISOR (DIV)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_rd    (src_rd),
        .txd       (txd),
        .busy      (busy)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic c);
        src_valid = v;
        src_data  = d;
        clr       = c;
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Line level expected in a given bit slot of a frame carrying d
    function automatic logic expBit(input logic [7:0] d, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return d[slot-1];
        if (PAR == 1 && slot == 9) return ^d;
        return 1'b1;
    endfunction

    // Checks cycles 1..FLEN of a frame; entered just after the accept edge
    task automatic frameBody(input logic [7:0] d, input logic lastRd);
        for (int c = 1; c <= FLEN; c++) begin
            @(negedge clk);
            checkOutput($sformatf("txd_%h_c%0d", d, c), txd, expBit(d, (c - 1) / DIV));
            checkOutput($sformatf("busy_%h_c%0d", d, c), busy, 1'b1);
            checkOutput($sformatf("rd_%h_c%0d", d, c), src_rd, (c == FLEN) ? lastRd : 1'b0);
            nextCycle();
        end
    endtask

    task automatic checkIdle(input string tag);
        @(negedge clk);
        checkOutput({tag, "_txd"}, txd, 1'b1);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_rd"}, src_rd, 1'b0);
        nextCycle();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rstn       = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);

        // Reset state, with a word offered that must not be consumed
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1'b1, 8'h77, 1'b0);
        @(negedge clk);
        checkOutput("rst_txd", txd, 1'b1);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_rd", src_rd, 1'b0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        rstn = 1'b1;
        checkIdle("idle0");

        // 0xA5 frame, data changed upstream mid-frame
        applyStimulus(1'b1, 8'hA5, 1'b0);
        @(negedge clk);
        checkOutput("a5_rd_c0", src_rd, 1'b1);
        checkOutput("a5_busy_c0", busy, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 8'h5A, 1'b0);
        frameBody(8'hA5, 1'b0);
        checkIdle("a5_end");

        // Back-to-back 0x00 then 0xFF with valid held high
        applyStimulus(1'b1, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("b2b_rd_c0", src_rd, 1'b1);
        nextCycle();
        applyStimulus(1'b1, 8'hFF, 1'b0);
        frameBody(8'h00, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0);
        frameBody(8'hFF, 1'b0);
        checkIdle("b2b_end");

        // 0x01 frame, parity bit 1 in the parity build
        applyStimulus(1'b1, 8'h01, 1'b0);
        @(negedge clk);
        checkOutput("x01_rd_c0", src_rd, 1'b1);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0);
        frameBody(8'h01, 1'b0);
        checkIdle("x01_end");

        // Synchronous clear at cycle 15 of a 0xA5 frame, valid offered meanwhile
        applyStimulus(1'b1, 8'hA5, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0);
        repeat (14) nextCycle();
        applyStimulus(1'b1, 8'h3C, 1'b1);
        @(negedge clk);
        checkOutput("clr_c15_busy", busy, 1'b1);
        checkOutput("clr_c15_rd", src_rd, 1'b0);
        nextCycle();
        @(negedge clk);
        checkOutput("clr_c16_txd", txd, 1'b1);
        checkOutput("clr_c16_busy", busy, 1'b0);
        checkOutput("clr_c16_rd", src_rd, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkIdle("clr_after");

        // Asynchronous reset at cycle 10 of a frame, then resume with a waiting word
        applyStimulus(1'b1, 8'h81, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0);
        repeat (9) nextCycle();
        #1;
        rstn = 1'b0;
        applyStimulus(1'b1, 8'h3C, 1'b0);
        #1;
        checkOutput("arst_txd", txd, 1'b1);
        checkOutput("arst_busy", busy, 1'b0);
        checkOutput("arst_rd", src_rd, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("arst_rel_rd", src_rd, 1'b1);
        checkOutput("arst_rel_busy", busy, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 8'h00, 1'b0);
        frameBody(8'h3C, 1'b0);
        checkIdle("arst_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
